// File: rtl/swd_transact_if.sv
// swd_transact_if: host request/response and bit-engine signals of the SWD transaction sequencer
interface swd_transact_if;
    logic go;
    logic apndp;
    logic rnw;
    logic [1:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [2:0] ack;
    logic perr;
    logic done;
    logic busy;
    logic [4:0] eBits;
    logic eUseParity;
    logic eTxReq;
    logic eRxReq;
    logic [31:0] eDataTo;
    logic [31:0] eDataFrom;
    logic eParityGood;
    logic eBusy;
    modport slave (
        input go, apndp, rnw, addr, wdata, eDataFrom, eParityGood, eBusy,
        output rdata, ack, perr, done, busy, eBits, eUseParity, eTxReq, eRxReq, eDataTo
    );
    modport master (
        output go, apndp, rnw, addr, wdata, eDataFrom, eParityGood, eBusy,
        input rdata, ack, perr, done, busy, eBits, eUseParity, eTxReq, eRxReq, eDataTo
    );
endinterface

// File: rtl/swd_transact.sv
// swd_transact: sequences header, ACK, data and idle-trailer operations through the SWD bit engine
module swd_transact #(
    parameter int RETRIES = 4,
    parameter int IDLE_BITS = 8,
    parameter int GAP_CYCLES = 16
) (
    input logic clk,
    input logic rst,
    swd_transact_if.slave bus
);
    localparam logic [2:0] P_IDLE = 3'd0;
    localparam logic [2:0] P_HDR = 3'd1;
    localparam logic [2:0] P_ACK = 3'd2;
    localparam logic [2:0] P_RD = 3'd3;
    localparam logic [2:0] P_WR = 3'd4;
    localparam logic [2:0] P_TRAIL = 3'd5;
    localparam logic [2:0] P_DONE = 3'd6;
    localparam logic [1:0] S_REQ = 2'd0;
    localparam logic [1:0] S_WAITHI = 2'd1;
    localparam logic [1:0] S_WAITLO = 2'd2;
    localparam logic [1:0] S_GAP = 2'd3;
    localparam int RW = RETRIES > 0 ? $clog2(RETRIES + 1) : 1;
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    localparam logic [4:0] TRAIL_BITS = 5'(IDLE_BITS > 0 ? IDLE_BITS - 1 : 0);

    logic [2:0] phase;
    logic [2:0] nextPhase;
    logic [1:0] sub;
    logic [RW-1:0] retryCnt;
    logic [GW-1:0] gapCnt;
    logic apReg;
    logic rnwReg;
    logic [1:0] addrReg;
    logic [31:0] wdataReg;
    logic [7:0] header;
    logic opTx;
    logic [4:0] opBits;
    logic opPar;
    logic [31:0] opData;

    // Header word and the engine operation that belongs to the current phase
    always_comb begin
        header = {1'b1, 1'b0, apReg ^ rnwReg ^ addrReg[0] ^ addrReg[1], addrReg, rnwReg, apReg, 1'b1};
        opTx = phase == P_HDR || phase == P_WR || phase == P_TRAIL;
        opBits = phase == P_HDR ? 5'd7 : phase == P_ACK ? 5'd2 : phase == P_TRAIL ? TRAIL_BITS : 5'd31;
        opPar = phase == P_RD || phase == P_WR;
        opData = phase == P_HDR ? {24'h0, header} : phase == P_WR ? wdataReg : 32'h0;
    end

    // Phase that follows once the current operation's gap has elapsed
    always_comb begin
        nextPhase = phase == P_HDR ? P_ACK
            : phase == P_ACK ? (bus.ack == 3'b001 ? (rnwReg ? P_RD : P_WR)
                : (bus.ack == 3'b010 && retryCnt < RW'(RETRIES)) ? P_HDR : P_DONE)
            : ((phase == P_RD || phase == P_WR) && IDLE_BITS > 0) ? P_TRAIL : P_DONE;
    end

    // Request acceptance, engine handshake, result capture and completion
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= P_IDLE;
            sub <= S_REQ;
            retryCnt <= '0;
            gapCnt <= '0;
            apReg <= 1'b0;
            rnwReg <= 1'b0;
            addrReg <= 2'b00;
            wdataReg <= 32'h0;
            bus.rdata <= 32'h0;
            bus.ack <= 3'b000;
            bus.perr <= 1'b0;
            bus.done <= 1'b0;
            bus.busy <= 1'b0;
            bus.eBits <= 5'd0;
            bus.eUseParity <= 1'b0;
            bus.eTxReq <= 1'b0;
            bus.eRxReq <= 1'b0;
            bus.eDataTo <= 32'h0;
        end else begin
            bus.done <= 1'b0;
            if (phase == P_IDLE) begin
                if (bus.go) begin
                    apReg <= bus.apndp;
                    rnwReg <= bus.rnw;
                    addrReg <= bus.addr;
                    wdataReg <= bus.wdata;
                    bus.busy <= 1'b1;
                    bus.ack <= 3'b000;
                    bus.perr <= 1'b0;
                    bus.rdata <= 32'h0;
                    phase <= P_HDR;
                    sub <= S_REQ;
                end
            end else if (phase == P_DONE) begin
                bus.done <= 1'b1;
                bus.busy <= 1'b0;
                retryCnt <= '0;
                phase <= P_IDLE;
            end else begin
                case (sub)
                    S_REQ: begin
                        bus.eBits <= opBits;
                        bus.eUseParity <= opPar;
                        bus.eDataTo <= opData;
                        bus.eTxReq <= opTx;
                        bus.eRxReq <= !opTx;
                        sub <= S_WAITHI;
                    end
                    S_WAITHI: if (bus.eBusy) begin
                        bus.eTxReq <= 1'b0;
                        bus.eRxReq <= 1'b0;
                        sub <= S_WAITLO;
                    end
                    S_WAITLO: if (!bus.eBusy) begin
                        if (phase == P_ACK) bus.ack <= bus.eDataFrom[2:0];
                        if (phase == P_RD) begin
                            bus.rdata <= bus.eDataFrom;
                            bus.perr <= !bus.eParityGood;
                        end
                        gapCnt <= GW'(GAP_CYCLES - 1);
                        sub <= S_GAP;
                    end
                    default: if (gapCnt == '0) begin
                        if (phase == P_ACK && nextPhase == P_HDR) retryCnt <= retryCnt + 1'b1;
                        phase <= nextPhase;
                        sub <= S_REQ;
                    end else begin
                        gapCnt <= gapCnt - 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_swd_transact.sv
// tb_swd_transact: scoreboard bench for swd_transact with a behavioural bit-engine model
module tb_swd_transact;
    localparam int RETRIES = 4;
    localparam int IDLE_BITS = 8;
    localparam int GAP_CYCLES = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    swd_transact_if bus();
    swd_transact #(.RETRIES(RETRIES), .IDLE_BITS(IDLE_BITS), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int nTests = 0;
    int nFail = 0;
    int doneCnt = 0;
    int hdrCnt = 0;
    logic [7:0] lastHdr = 8'h0;
    logic [38:0] opQ[$];
    logic [35:0] doneQ[$];
    logic [2:0] ackScript[$];
    logic [31:0] mRd = 32'h0;
    logic mPg = 1'b1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [38:0] mkOp(input logic tx, input int bits, input logic par, input logic [31:0] d);
        return {tx, 5'(bits), par, d};
    endfunction

    function automatic logic [7:0] hdrOf(input logic ap, input logic rw, input logic [1:0] ad);
        return {1'b1, 1'b0, ap ^ rw ^ ad[0] ^ ad[1], ad[1], ad[0], rw, ap, 1'b1};
    endfunction

    task automatic checkZero(input string tag);
        check({tag, "Out"}, 64'({bus.rdata, bus.ack, bus.perr, bus.done, bus.busy, bus.eBits,
                                 bus.eUseParity, bus.eTxReq, bus.eRxReq}), 64'h0);
        check({tag, "DataTo"}, 64'(bus.eDataTo), 64'h0);
    endtask

    // Engine model: acknowledges each request, stays busy for the bit count, returns scripted data
    initial begin
        int mSt;
        int cnt;
        logic t;
        logic [4:0] b;
        logic [38:0] e;
        mSt = 0;
        cnt = 0;
        t = 1'b0;
        b = 5'd0;
        bus.eBusy = 1'b0;
        bus.eDataFrom = 32'h0;
        bus.eParityGood = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                mSt = 0;
                bus.eBusy = 1'b0;
            end else if (mSt == 0) begin
                if (bus.eTxReq || bus.eRxReq) begin
                    check("reqExcl", 64'(bus.eTxReq & bus.eRxReq), 64'h0);
                    t = bus.eTxReq;
                    b = bus.eBits;
                    if (t && b == 5'd7 && bus.eDataTo != 32'h0) begin
                        hdrCnt++;
                        lastHdr = bus.eDataTo[7:0];
                    end
                    check("opExpected", 64'(opQ.size() != 0), 64'h1);
                    e = opQ.size() != 0 ? opQ.pop_front() : '1;
                    check("op", 64'({t, b, bus.eUseParity, t ? bus.eDataTo : 32'h0}), 64'(e));
                    cnt = 2;
                    mSt = 1;
                end
            end else if (mSt == 1) begin
                cnt--;
                if (cnt == 0) begin
                    bus.eBusy = 1'b1;
                    cnt = int'(b) + 1;
                    mSt = 2;
                end
            end else begin
                check("reqDrop", 64'(bus.eTxReq | bus.eRxReq), 64'h0);
                cnt--;
                if (cnt == 0) begin
                    check("opStable", 64'(bus.eBits), 64'(b));
                    if (!t && b == 5'd2) bus.eDataFrom = {29'h0, ackScript.size() != 0 ? ackScript.pop_front() : 3'b111};
                    if (!t && b == 5'd31) begin
                        bus.eDataFrom = mRd;
                        bus.eParityGood = mPg;
                    end
                    bus.eBusy = 1'b0;
                    mSt = 0;
                end
            end
        end
    end

    // Completion monitor: pops the expected result for every done pulse
    initial begin
        logic [35:0] e;
        forever begin
            @(negedge clk);
            if (bus.done) begin
                doneCnt++;
                check("doneExpected", 64'(doneQ.size() != 0), 64'h1);
                if (doneQ.size() != 0) begin
                    e = doneQ.pop_front();
                    check("ack", 64'(bus.ack), 64'(e[35:33]));
                    check("rdata", 64'(bus.rdata), 64'(e[32:1]));
                    check("perr", 64'(bus.perr), 64'(e[0]));
                end
            end
        end
    end

    task automatic startTxn(input logic ap, input logic rw, input logic [1:0] ad, input logic [31:0] wd,
                            input logic [31:0] rd, input logic pg, output int d0);
        int r;
        logic [2:0] fin;
        r = 0;
        fin = 3'b000;
        mRd = rd;
        mPg = pg;
        for (int i = 0; i < ackScript.size(); i++) begin
            opQ.push_back(mkOp(1'b1, 7, 1'b0, {24'h0, hdrOf(ap, rw, ad)}));
            opQ.push_back(mkOp(1'b0, 2, 1'b0, 32'h0));
            fin = ackScript[i];
            if (fin == 3'b010 && r < RETRIES) begin
                r++;
                continue;
            end
            if (fin == 3'b001) begin
                opQ.push_back(mkOp(!rw, 31, 1'b1, rw ? 32'h0 : wd));
                if (IDLE_BITS > 0) opQ.push_back(mkOp(1'b1, IDLE_BITS - 1, 1'b0, 32'h0));
            end
            break;
        end
        doneQ.push_back({fin, (fin == 3'b001 && rw) ? rd : 32'h0, fin == 3'b001 && rw && !pg});
        d0 = doneCnt;
        @(negedge clk);
        bus.apndp = ap;
        bus.rnw = rw;
        bus.addr = ad;
        bus.wdata = wd;
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        check("busy", 64'(bus.busy), 64'h1);
        check("ackClr", 64'(bus.ack), 64'h0);
        check("rdataClr", 64'(bus.rdata), 64'h0);
    endtask

    task automatic finishTxn(input int d0);
        int n;
        n = 0;
        while (doneCnt == d0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("doneSeen", 64'(doneCnt != d0), 64'h1);
        repeat (30) @(negedge clk);
        check("oneDone", 64'(doneCnt - d0), 64'h1);
        check("opsLeft", 64'(opQ.size()), 64'h0);
        check("idleBusy", 64'(bus.busy), 64'h0);
    endtask

    // Directed transactions covering read, write, bad parity, WAIT exhaustion, FAULT and mid-transfer reset
    initial begin
        int d0;
        int h0;
        int n;
        bus.go = 1'b0;
        bus.apndp = 1'b0;
        bus.rnw = 1'b0;
        bus.addr = 2'b00;
        bus.wdata = 32'h0;
        repeat (3) @(negedge clk);
        checkZero("reset");
        rst = 1'b0;
        ackScript = '{3'b001};
        h0 = hdrCnt;
        startTxn(1'b0, 1'b1, 2'b00, 32'h0, 32'h2BA01477, 1'b1, d0);
        finishTxn(d0);
        check("hdrDpRd", 64'(lastHdr), 64'hA5);
        check("hdrCntRd", 64'(hdrCnt - h0), 64'h1);
        ackScript = '{3'b001};
        startTxn(1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 1'b1, d0);
        finishTxn(d0);
        check("hdrDpWr", 64'(lastHdr), 64'hB1);
        ackScript = '{3'b001};
        startTxn(1'b1, 1'b1, 2'b01, 32'h0, 32'hDEADBEEF, 1'b0, d0);
        finishTxn(d0);
        ackScript = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010};
        h0 = hdrCnt;
        startTxn(1'b1, 1'b1, 2'b11, 32'h0, 32'h11111111, 1'b1, d0);
        finishTxn(d0);
        check("hdrCntWait", 64'(hdrCnt - h0), 64'd5);
        ackScript = '{3'b100};
        startTxn(1'b0, 1'b0, 2'b01, 32'h12345678, 32'h0, 1'b1, d0);
        repeat (8) @(negedge clk);
        check("busyBeforeGo", 64'(bus.busy), 64'h1);
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        finishTxn(d0);
        ackScript = '{3'b001};
        startTxn(1'b1, 1'b1, 2'b11, 32'h0, 32'hCAFEF00D, 1'b1, d0);
        n = 0;
        while (!(bus.eRxReq && bus.eBits == 5'd31) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("rdReached", 64'(bus.eRxReq && bus.eBits == 5'd31), 64'h1);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkZero("midRst");
        opQ.delete();
        doneQ.delete();
        ackScript.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("noDoneAfterRst", 64'(doneCnt - d0), 64'h0);
        ackScript = '{3'b010, 3'b001};
        startTxn(1'b0, 1'b1, 2'b01, 32'h0, 32'h0BADC0DE, 1'b1, d0);
        finishTxn(d0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule

// File: doc/swd_transact.md
Name: swd_transact

Overview:
SWD transaction sequencer sitting directly upstream of the SWD bit engine. It turns one host request (APnDP, RnW, A[3:2], wdata) into the sequence of engine operations: 8-bit header TX, 3-bit ACK RX, 32-bit+parity data RX or TX, and optional trailing idle zeros. It handles WAIT retries and reports ACK, read data and parity status back to the host side in a single completion pulse.

Parameters:
RETRIES, 4, maximum header re-issues after a WAIT ACK before giving up.
IDLE_BITS, 8, number of trailing zero bits sent after a completed OK transaction; 0 disables the trailer. Range 0..32.
GAP_CYCLES, 16, minimum clk cycles that a request line to the engine is held low between engine operations. Must be at least 2 engine tick periods.

Ports:
clk  in  1  master clock
rst  in  1  synchronous, active-high reset
go  in  1  start a transaction; sampled only in IDLE
apndp  in  1  0=DP, 1=AP
rnw  in  1  1=read, 0=write
addr  in  2  A[3:2]
wdata  in  32  write data
rdata  out  32  read data, valid when done=1 and rnw=1
ack  out  3  ACK as received, LSB = first bit on the wire (OK=3'b001, WAIT=3'b010, FAULT=3'b100)
perr  out  1  read-data parity mismatch
done  out  1  one-cycle completion pulse
busy  out  1  transaction in progress
eBits  out  5  to engine: bit count minus 1
eUseParity  out  1  to engine: parity flag
eTxReq  out  1  to engine: TX request (rising edge significant)
eRxReq  out  1  to engine: RX request
eDataTo  out  32  to engine: TX data, LSB first
eDataFrom  in  32  from engine: RX data
eParityGood  in  1  from engine: parity result
eBusy  in  1  from engine: busy

Behaviour:
- Reset: all outputs 0, state IDLE, retry counter 0. Reset mid-transaction abandons it immediately, with no done pulse.
- Accept: in IDLE with go=1, latch apndp/rnw/addr/wdata, set busy=1 on the next cycle, and clear ack, perr and rdata. go while busy=1 is ignored.
- Header word, LSB first: b0=1 (start), b1=apndp, b2=rnw, b3=addr[0], b4=addr[1], b5=XOR(b1..b4), b6=0 (stop), b7=1 (park).
- Engine operation handshake (sub-FSM REQ→WAITHI→WAITLO→GAP):
  - REQ: drive eBits, eUseParity and eDataTo, and raise one request line.
  - WAITHI: hold the request until eBusy=1, then drop it.
  - WAITLO: wait for eBusy=0.
  - GAP: hold both request lines low for GAP_CYCLES cycles.
  - eBits, eUseParity and eDataTo stay stable from REQ until the GAP starts.
  - eTxReq and eRxReq are never both high.
- Phase FSM:
  - IDLE→HDR: TX, bits=7, no parity, data=header.
  - HDR→ACK: RX, bits=2, no parity. After WAITLO, ack<=eDataFrom[2:0].
  - ACK=001 and rnw=1 → RD: RX, bits=31, parity on. After WAITLO, rdata<=eDataFrom and perr<=!eParityGood.
  - ACK=001 and rnw=0 → WR: TX, bits=31, parity on, data=wdata.
  - RD or WR → TRAIL if IDLE_BITS>0: TX, bits=IDLE_BITS-1, no parity, data=0. Otherwise → DONE.
  - ACK=010 with retry counter < RETRIES → increment counter, GAP, then re-enter HDR.
  - ACK=010 with retries exhausted → DONE.
  - ACK of FAULT, 000, 111 or any other value → DONE. There is no data phase and no trailer.
  - DONE: done=1 for one cycle, busy<=0, retry counter<=0, → IDLE.
- ack, rdata and perr hold their values until the next accepted go.
- perr is only ever set in RD.
- The earliest done is at least the sum of engine operation times plus one GAP per phase; there is no fixed latency.

Test Plan:
- DP read addr 0 (apndp=0, rnw=1, addr=00), engine model returns ACK 001 and data 0x2BA01477 with good parity → header eDataTo=0xA5 with eBits=7; rdata=0x2BA01477, perr=0, ack=001; trailer of 8 zeros; exactly one done pulse.
- DP write addr 2 (addr=10), wdata=0x00000000, ACK 001 → header 0xB1; data TX eBits=31 with eUseParity=1 and eDataTo=0; done with ack=001.
- AP read with bad parity from the model → perr=1, rdata still updated, done asserted.
- WAIT returned 5 times with RETRIES=4 → exactly 5 headers sent; done with ack=010; no data phase.
- FAULT ACK (100) on a write → no data TX, no trailer, done with ack=100. go pulsed again while busy → ignored, so exactly one transaction occurs.
- rst asserted during the RD phase → all outputs 0 next cycle, request lines low, no done pulse. A following go runs a clean transaction.
